// File: rtl/vend_fault_pkg.sv
// Shared types and constants for the vending fault manager.
package vend_fault_pkg;

  typedef enum logic [2:0] {
    MONITOR   = 3'd0,
    WAIT_IDLE = 3'd1,
    RESYNC    = 3'd2,
    SETTLE    = 3'd3,
    LOCKOUT   = 3'd4
  } state_e;

  // Bit positions inside fault_src.
  localparam int unsigned SRC_COIN = 0;
  localparam int unsigned SRC_CAN  = 1;
  localparam int unsigned SRC_VEND = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fault_debounce.sv
// Persistence filter: confirmed_o pulses on the CONFIRM_CYC-th consecutive enabled cycle.
module fault_debounce #(
  parameter int unsigned CONFIRM_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic confirmed_o
);

  localparam int unsigned CW = $clog2(CONFIRM_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(CONFIRM_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign confirmed_o = en_i && !clr_i && (cnt_q == LAST);

  // Count consecutive enabled cycles; any gap, clear or confirmation restarts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || confirmed_o) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_fault_manager.sv
// Confirms replica disagreements, resyncs the replicas once idle, and locks
// the machine out of service after repeated failed recoveries.
module vend_fault_manager
  import vend_fault_pkg::*;
#(
  parameter int unsigned CONFIRM_CYC = 4,
  parameter int unsigned RESYNC_LEN  = 2,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_fail,
  input  logic             can_fail,
  input  logic             vend_fail,
  input  logic             vend_idle,
  input  logic             service_clear,
  output logic             inhibit,
  output logic             resync,
  output logic             lockout,
  output logic [2:0]       fault_src,
  output logic [CNT_W-1:0] fault_count
);

  localparam int unsigned CW = $clog2(max3(RESYNC_LEN, SETTLE_CYC, MAX_RETRY)) + 1;
  localparam logic [CW-1:0] RS_LAST = CW'(RESYNC_LEN - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RT_MAX  = CW'(MAX_RETRY);

  state_e            state_q, state_d;
  logic              inhibit_q, inhibit_d;
  logic              resync_q, resync_d;
  logic              lockout_q, lockout_d;
  logic [2:0]        src_q, src_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CW-1:0]     retry_q, retry_d;
  logic [CW-1:0]     tmr_q, tmr_d;
  logic [CW-1:0]     retry_inc;
  logic [2:0]        flags;
  logic              fail_any;
  logic              confirmed;

  // Gather the replica flags into fault_src bit order.
  always_comb begin
    flags           = '0;
    flags[SRC_COIN] = coin_fail;
    flags[SRC_CAN]  = can_fail;
    flags[SRC_VEND] = vend_fail;
  end

  assign fail_any  = |flags;
  assign retry_inc = retry_q + 1'b1;

  fault_debounce #(.CONFIRM_CYC(CONFIRM_CYC)) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .en_i        (fail_any),
    .clr_i       (state_q != MONITOR),
    .confirmed_o (confirmed)
  );

  // Episode sequencing; tmr is shared by RESYNC and SETTLE since they never overlap.
  always_comb begin
    state_d   = state_q;
    inhibit_d = inhibit_q;
    resync_d  = resync_q;
    lockout_d = lockout_q;
    src_d     = src_q;
    fcnt_d    = fcnt_q;
    retry_d   = retry_q;
    tmr_d     = tmr_q;
    unique case (state_q)
      MONITOR: begin
        if (confirmed) begin
          state_d   = WAIT_IDLE;
          inhibit_d = 1'b1;
          src_d     = src_q | flags;
          if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        src_d = src_q | flags;
        if (vend_idle) begin
          state_d  = RESYNC;
          resync_d = 1'b1;
          tmr_d    = '0;
        end
      end
      RESYNC: begin
        if (tmr_q == RS_LAST) begin
          state_d  = SETTLE;
          resync_d = 1'b0;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SETTLE: begin
        tmr_d = '0;
        if (fail_any) begin
          retry_d = retry_inc;
          src_d   = src_q | flags;
          if (retry_inc == RT_MAX) begin
            state_d   = LOCKOUT;
            lockout_d = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else if (tmr_q == ST_LAST) begin
          state_d   = MONITOR;
          inhibit_d = 1'b0;
          src_d     = '0;
          retry_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (service_clear) begin
          state_d   = RESYNC;
          lockout_d = 1'b0;
          retry_d   = '0;
          resync_d  = 1'b1;
          tmr_d     = '0;
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  // State and registered outputs; reset aborts any episode immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MONITOR;
      inhibit_q <= 1'b0;
      resync_q  <= 1'b0;
      lockout_q <= 1'b0;
      src_q     <= '0;
      fcnt_q    <= '0;
      retry_q   <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      inhibit_q <= inhibit_d;
      resync_q  <= resync_d;
      lockout_q <= lockout_d;
      src_q     <= src_d;
      fcnt_q    <= fcnt_d;
      retry_q   <= retry_d;
      tmr_q     <= tmr_d;
    end
  end

  assign inhibit     = inhibit_q;
  assign resync      = resync_q;
  assign lockout     = lockout_q;
  assign fault_src   = src_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_vend_fault_manager.sv
// Directed bench for vend_fault_manager with a queue-based expected-output scoreboard.
module tb_vend_fault_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_fail, can_fail, vend_fail, vend_idle, service_clear;
  logic       inhibit, resync, lockout;
  logic [2:0] fault_src;
  logic [7:0] fault_count;
  logic [13:0] obs;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  vend_fault_manager dut (
    .clk           (clk),
    .reset         (reset),
    .coin_fail     (coin_fail),
    .can_fail      (can_fail),
    .vend_fail     (vend_fail),
    .vend_idle     (vend_idle),
    .service_clear (service_clear),
    .inhibit       (inhibit),
    .resync        (resync),
    .lockout       (lockout),
    .fault_src     (fault_src),
    .fault_count   (fault_count)
  );

  assign obs = {inhibit, resync, lockout, fault_src, fault_count};

  function automatic logic [13:0] pk(input logic i, input logic r, input logic l,
                                     input logic [2:0] s, input logic [7:0] c);
    return {i, r, l, s, c};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [13:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic cmp();
    sb_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic now_chk(input string tag, input logic [13:0] exp);
    push(tag, exp);
    cmp();
  endtask

  task automatic expect_after(input string tag, input int n, input logic [13:0] exp);
    push(tag, exp);
    step(n);
    cmp();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  localparam logic [13:0] ZERO = 14'h0;

  initial begin
    reset = 1'b0; coin_fail = 1'b0; can_fail = 1'b0; vend_fail = 1'b0;
    vend_idle = 1'b0; service_clear = 1'b0;
    #2;
    now_chk("reset_state", ZERO);
    step(2);
    reset = 1'b1;
    step(1);
    now_chk("post_reset", ZERO);

    // 3-cycle glitch is filtered.
    coin_fail = 1'b1;
    expect_after("glitch_hi", 3, ZERO);
    coin_fail = 1'b0;
    expect_after("glitch_lo", 3, ZERO);

    // Clean episode through resync and settle.
    vend_idle = 1'b1; can_fail = 1'b1;
    expect_after("t2_pre",    3, ZERO);
    expect_after("t2_conf",   1, pk(1, 0, 0, 3'b010, 8'd1));
    expect_after("t2_rs1",    1, pk(1, 1, 0, 3'b010, 8'd1));
    expect_after("t2_rs2",    1, pk(1, 1, 0, 3'b010, 8'd1));
    can_fail = 1'b0;
    expect_after("t2_rsoff",  1, pk(1, 0, 0, 3'b010, 8'd1));
    expect_after("t2_settle", 7, pk(1, 0, 0, 3'b010, 8'd1));
    expect_after("t2_recov",  1, pk(0, 0, 0, 3'b000, 8'd1));

    // Confirmed while busy: wait for idle, even after the flag drops.
    vend_idle = 1'b0; vend_fail = 1'b1;
    expect_after("t3_pre",  3, pk(0, 0, 0, 3'b000, 8'd1));
    expect_after("t3_conf", 1, pk(1, 0, 0, 3'b100, 8'd2));
    for (int i = 0; i < 10; i++) expect_after("t3_hold", 1, pk(1, 0, 0, 3'b100, 8'd2));
    service_clear = 1'b1;
    expect_after("t3_svc_ignored", 1, pk(1, 0, 0, 3'b100, 8'd2));
    service_clear = 1'b0; vend_fail = 1'b0;
    expect_after("t3_dropped", 2, pk(1, 0, 0, 3'b100, 8'd2));
    vend_idle = 1'b1;
    expect_after("t3_rs1",     1, pk(1, 1, 0, 3'b100, 8'd2));
    expect_after("t3_rs2",     1, pk(1, 1, 0, 3'b100, 8'd2));
    expect_after("t3_rsoff",   1, pk(1, 0, 0, 3'b100, 8'd2));
    expect_after("t3_settle",  7, pk(1, 0, 0, 3'b100, 8'd2));
    expect_after("t3_recov",   1, pk(0, 0, 0, 3'b000, 8'd2));

    // Persistent fault escalates to lockout; service_clear retries.
    do_reset();
    vend_idle = 1'b1; coin_fail = 1'b1;
    expect_after("t4_conf",     4,  pk(1, 0, 0, 3'b001, 8'd1));
    expect_after("t4_prelock",  11, pk(1, 0, 0, 3'b001, 8'd1));
    expect_after("t4_lock",     1,  pk(1, 0, 1, 3'b001, 8'd1));
    can_fail = 1'b1;
    expect_after("t4_frozen",   2,  pk(1, 0, 1, 3'b001, 8'd1));
    can_fail = 1'b0; service_clear = 1'b1;
    expect_after("t4_clr_rs1",  1,  pk(1, 1, 0, 3'b001, 8'd1));
    service_clear = 1'b0;
    expect_after("t4_clr_rs2",  1,  pk(1, 1, 0, 3'b001, 8'd1));
    expect_after("t4_relock_pre", 9, pk(1, 0, 0, 3'b001, 8'd1));
    expect_after("t4_relock",   1,  pk(1, 0, 1, 3'b001, 8'd1));
    coin_fail = 1'b0;
    do_reset();
    now_chk("t4_reset", ZERO);

    // Simultaneous flags count as one fault.
    vend_idle = 1'b0; coin_fail = 1'b1; vend_fail = 1'b1;
    expect_after("t5_pre",  3, ZERO);
    expect_after("t5_conf", 1, pk(1, 0, 0, 3'b101, 8'd1));

    // Asynchronous reset during resync.
    vend_idle = 1'b1;
    expect_after("t6_rs", 1, pk(1, 1, 0, 3'b101, 8'd1));
    #3 reset = 1'b0;
    #1 now_chk("t6_async", ZERO);
    coin_fail = 1'b0; vend_fail = 1'b0;
    #2 reset = 1'b1;
    step(1);
    now_chk("t6_idle", ZERO);
    coin_fail = 1'b1;
    expect_after("t6_pre",  3, ZERO);
    expect_after("t6_conf", 1, pk(1, 0, 0, 3'b001, 8'd1));
    coin_fail = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
